// File: rtl/ipv4_pkg.sv
// Shared IPv4 receive definitions: header constants, protocol numbers, error codes, FSM states.
package ipv4_pkg;

  localparam int unsigned OCT_W = 8;

  localparam logic [3:0] IPV4_VERSION = 4'd4;
  localparam logic [3:0] IHL_MIN      = 4'd5;

  localparam logic [7:0] PROTO_ICMP = 8'd1;
  localparam logic [7:0] PROTO_UDP  = 8'd17;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_HDR   = 3'd1,
    ERR_CSUM  = 3'd2,
    ERR_DST   = 3'd3,
    ERR_FRAG  = 3'd4,
    ERR_TRUNC = 3'd5,
    ERR_LEN   = 3'd6
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_OPTIONS = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DONE    = 3'd4,
    S_DROP    = 3'd5
  } rx_state_t;

endpackage

// File: rtl/ipv4_csum.sv
// Byte-serial ones'-complement checksum over big-endian 16-bit words.
// ok reflects the folded sum including the current (odd) byte of a word pair.
module ipv4_csum (
  input  logic       RX_CLK,
  input  logic       rst,
  input  logic       clear,
  input  logic       byte_valid,
  input  logic [7:0] data_byte,
  output logic       ok
);

  logic [15:0] acc;
  logic [15:0] acc_next;
  logic [16:0] sum17;
  logic [7:0]  hi;
  logic        odd;

  // End-around carry: a single fold suffices since sum17 never exceeds 17'h1FFFE.
  always_comb begin
    sum17    = {1'b0, acc} + {1'b0, hi, data_byte};
    acc_next = sum17[15:0] + 16'(sum17[16]);
    ok       = (acc_next == 16'hFFFF);
  end

  // clear may coincide with the first byte of a new header; that byte is kept.
  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      acc <= '0;
      hi  <= '0;
      odd <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      odd <= byte_valid;
      if (byte_valid) hi <= data_byte;
    end else if (byte_valid) begin
      if (odd) acc <= acc_next;
      else     hi  <= data_byte;
      odd <= ~odd;
    end
  end

endmodule

// File: rtl/rx_ipv4.sv
// IPv4 receive parser: validates the header, strips header/options, forwards the payload
// and reports metadata, a completion pulse or an error code.
module rx_ipv4
  import ipv4_pkg::*;
#(
  parameter int unsigned OCT          = 8,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic           RX_CLK,
  input  logic           rst,
  input  logic [31:0]    ip_addr,
  input  logic           rx_payload_ipv4,
  input  logic [OCT-1:0] rx_payload,
  output logic           rx_data_valid,
  output logic [OCT-1:0] rx_data,
  output logic [31:0]    rx_src_ip,
  output logic [7:0]     rx_protocol,
  output logic [15:0]    rx_data_len,
  output logic           rx_ipv4_irq,
  output logic           rx_ipv4_err,
  output logic [2:0]     rx_err_code
);

  rx_state_t   state;
  logic [15:0] byte_idx;
  logic [15:0] pay_cnt;
  logic [15:0] total_len;
  logic [3:0]  ihl_r;
  logic [7:0]  proto_r;
  logic [31:0] src_r;
  logic [23:0] dst_r;
  logic        valid_q;

  logic [7:0]  b;
  logic        start;
  logic        hdr_byte;
  logic        hdr_last;
  logic        dst_ok;
  logic        csum_ok;
  logic [15:0] idx;
  logic [15:0] hdr_len;
  logic [15:0] pay_next;
  logic [3:0]  ihl_cur;
  err_code_t   hdr_err;

  assign b = 8'(rx_payload);

  ipv4_csum u_csum (
    .RX_CLK     (RX_CLK),
    .rst        (rst),
    .clear      (state == S_IDLE),
    .byte_valid (hdr_byte),
    .data_byte  (b),
    .ok         (csum_ok)
  );

  // A frame starts only on a rising valid seen from IDLE; byte 0 is parsed that cycle.
  always_comb begin
    start    = (state == S_IDLE) && rx_payload_ipv4 && !valid_q;
    hdr_byte = start || (((state == S_HEADER) || (state == S_OPTIONS)) && rx_payload_ipv4);
    idx      = (state == S_IDLE) ? 16'd0 : byte_idx;
    ihl_cur  = (state == S_IDLE) ? b[3:0] : ihl_r;
    hdr_len  = {10'd0, ihl_cur, 2'b00};
    hdr_last = hdr_byte && (idx == hdr_len - 16'd1);
    dst_ok   = ({dst_r, b} == ip_addr) || (ACCEPT_BCAST && ({dst_r, b} == 32'hFFFF_FFFF));
    pay_next = pay_cnt + 16'd1;
    hdr_err  = ERR_NONE;
    if (!hdr_byte)
      hdr_err = ERR_NONE;
    else if ((idx == 16'd0) && ((b[7:4] != IPV4_VERSION) || (b[3:0] < IHL_MIN)))
      hdr_err = ERR_HDR;
    else if (hdr_last && (total_len < hdr_len))
      hdr_err = ERR_LEN;
    else if (hdr_last && !csum_ok)
      hdr_err = ERR_CSUM;
    else if ((idx == 16'd19) && !dst_ok)
      hdr_err = ERR_DST;
    else if (((idx == 16'd6) && (b[5] || (b[4:0] != 5'd0))) || ((idx == 16'd7) && (b != 8'd0)))
      hdr_err = ERR_FRAG;
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state         <= S_IDLE;
      byte_idx      <= '0;
      pay_cnt       <= '0;
      total_len     <= '0;
      ihl_r         <= '0;
      proto_r       <= '0;
      src_r         <= '0;
      dst_r         <= '0;
      valid_q       <= 1'b1;
      rx_data_valid <= 1'b0;
      rx_data       <= '0;
      rx_src_ip     <= '0;
      rx_protocol   <= '0;
      rx_data_len   <= '0;
      rx_ipv4_irq   <= 1'b0;
      rx_ipv4_err   <= 1'b0;
      rx_err_code   <= '0;
    end else begin
      valid_q       <= rx_payload_ipv4;
      rx_data_valid <= 1'b0;
      rx_ipv4_irq   <= 1'b0;
      rx_ipv4_err   <= 1'b0;
      if (hdr_byte) begin
        byte_idx <= idx + 16'd1;
        case (idx)
          16'd0:                       ihl_r           <= b[3:0];
          16'd2:                       total_len[15:8] <= b;
          16'd3:                       total_len[7:0]  <= b;
          16'd9:                       proto_r         <= b;
          16'd12, 16'd13, 16'd14, 16'd15: src_r        <= {src_r[23:0], b};
          16'd16, 16'd17, 16'd18:      dst_r           <= {dst_r[15:0], b};
          default: ;
        endcase
        if (hdr_err != ERR_NONE) begin
          rx_ipv4_err <= 1'b1;
          rx_err_code <= hdr_err;
          state       <= S_DROP;
        end else if (hdr_last) begin
          rx_src_ip   <= src_r;
          rx_protocol <= proto_r;
          rx_data_len <= total_len - hdr_len;
          pay_cnt     <= '0;
          state       <= (total_len == hdr_len) ? S_DONE : S_PAYLOAD;
        end else begin
          state <= (idx >= 16'd19) ? S_OPTIONS : S_HEADER;
        end
      end else begin
        case (state)
          S_HEADER, S_OPTIONS: begin
            rx_ipv4_err <= 1'b1;
            rx_err_code <= ERR_TRUNC;
            state       <= S_IDLE;
          end
          S_PAYLOAD: begin
            if (rx_payload_ipv4) begin
              rx_data       <= rx_payload;
              rx_data_valid <= 1'b1;
              pay_cnt       <= pay_next;
              if (pay_next == rx_data_len) state <= S_DONE;
            end else begin
              rx_ipv4_err <= 1'b1;
              rx_err_code <= ERR_TRUNC;
              state       <= S_IDLE;
            end
          end
          S_DONE: begin
            if (!rx_payload_ipv4) begin
              rx_ipv4_irq <= 1'b1;
              state       <= S_IDLE;
            end
          end
          S_DROP: begin
            if (!rx_payload_ipv4) state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/rx_ipv4.md
Name: rx_ipv4

Overview:
- Downstream of the Ethernet receive stage; consumes its per-byte IPv4 payload stream (rx_payload_ipv4 / rx_payload) in the RX_CLK domain.
- Parses and validates the IPv4 header: version, IHL, checksum, fragmentation and destination address.
- Strips header and options; forwards exactly (total_length - IHL*4) payload bytes, discarding Ethernet padding and the trailing FCS.
- Reports per-packet metadata, a completion interrupt, or an error code.

Parameters:
- OCT, 8, byte width.
- ACCEPT_BCAST, 1, when 1, also accept destination 255.255.255.255.

Ports:
- RX_CLK  in  1  receive clock.
- rst  in  1  reset.
- ip_addr  in  32  local IPv4 address, static during a packet.
- rx_payload_ipv4  in  1  input byte valid; high for the contiguous frame body, low after it.
- rx_payload  in  8  input byte.
- rx_data_valid  out  1  payload byte valid.
- rx_data  out  8  payload byte.
- rx_src_ip  out  32  source address of the current/last packet.
- rx_protocol  out  8  protocol field.
- rx_data_len  out  16  payload length, total_length - IHL*4.
- rx_ipv4_irq  out  1  one-cycle pulse: good packet fully delivered.
- rx_ipv4_err  out  1  one-cycle pulse: packet dropped.
- rx_err_code  out  3  reason, valid with rx_ipv4_err; holds until the next error.

Behaviour:
- Reset and clock: rst is synchronous, active-high; clock is RX_CLK. Reset forces all outputs to 0 and the FSM to IDLE, including when reset arrives mid-packet.
- Byte counter: 16-bit byte_idx counts header bytes from 0.
- Checksum: 17-bit ones'-complement accumulator. Each even/odd byte pair forms a big-endian 16-bit word; carry folds back (end-around).
- FSM states:
  - IDLE: wait for rx_payload_ipv4 = 1; that byte is header byte 0 and is processed in the same cycle.
  - HEADER: bytes 0-19.
    - Byte 0: version must be 4 and IHL >= 5, else err 1.
    - Bytes 2-3: total_length.
    - Bytes 6-7: MF flag or nonzero fragment offset -> err 4.
    - Byte 9: protocol.
    - Bytes 12-15: source address.
    - Bytes 16-19: destination address. At byte 19, destination must equal ip_addr (or broadcast when ACCEPT_BCAST = 1), else err 3.
  - OPTIONS: bytes 20 to IHL*4-1. Summed into the checksum, not forwarded.
  - Header end (last header byte): the folded sum must equal 16'hFFFF, else err 2. total_length < IHL*4 -> err 6.
    - If accepted: latch rx_src_ip, rx_protocol, rx_data_len; go to PAYLOAD, or DONE if the payload length is 0.
    - Metadata is updated only on accepted headers; it holds otherwise.
  - PAYLOAD:
    - Each valid input byte -> rx_data with rx_data_valid = 1 on the next cycle (1-cycle latency, no bubbles).
    - After the rx_data_len-th byte, go to DONE.
  - DONE: ignore remaining bytes (padding/FCS) until rx_payload_ipv4 = 0, then pulse rx_ipv4_irq for 1 cycle and go to IDLE.
  - DROP: any error pulses rx_ipv4_err once with its code, forwards nothing more, waits for rx_payload_ipv4 = 0, then goes to IDLE.
- Truncation: rx_payload_ipv4 falls in HEADER, OPTIONS or PAYLOAD -> err 5, straight to IDLE. Bytes already forwarded stay forwarded; no irq.
- Error priority when several errors hit the same byte: 1 > 6 > 2 > 3 > 4. Only one err pulse per packet.
- A new packet is recognised only from IDLE. The input always has at least 1 invalid cycle between frames.
- rx_data holds its last value when rx_data_valid = 0.

Decomposition:
- Shared package ipv4_pkg:
  - Constants: IPV4_VERSION = 4, IHL_MIN = 5.
  - Protocol numbers: PROTO_ICMP = 1, PROTO_UDP = 17.
  - Error codes: ERR_HDR = 1, ERR_CSUM = 2, ERR_DST = 3, ERR_FRAG = 4, ERR_TRUNC = 5, ERR_LEN = 6.
  - FSM state encodings.
- One sub-module, ipv4_csum: clear, byte_valid, byte; output ok = (folded sum == 16'hFFFF). The same block is reusable later for TX checksum generation.

Test Plan:
- Good packet: IHL = 5, total_length = 28, proto 17, dst = ip_addr, 8 payload bytes 01..08, then 18 pad + 4 FCS bytes -> rx_data 01..08 on 8 consecutive cycles; rx_data_len = 8; rx_protocol = 17; one irq after valid falls; no err.
- Options: IHL = 6 (4 option bytes, included in checksum), 4-byte payload -> options not forwarded; only the 4 payload bytes appear; irq.
- Checksum corrupted by 1 bit -> err pulse, code 2; rx_data_valid never asserted; no irq.
- Destination mismatch -> code 3. Destination 255.255.255.255 with ACCEPT_BCAST = 1 -> accepted. MF = 1 -> code 4. Version 6 -> code 1 at byte 0.
- rx_payload_ipv4 drops after 5 of 8 payload bytes -> 5 bytes forwarded, err code 5, no irq. A next good packet is received normally.
- rst asserted mid-PAYLOAD -> all outputs 0 next cycle. Bytes still valid after reset are not parsed until a new rising valid from IDLE.
